acc_ctrl: RTL and testbench
===========================

# acc_ctrl

Sequencer for the time-step accumulator in the LSTM backprop datapath. On a `start` command it clears the accumulator, feeds it exactly `len` handshaked samples and presents the final sum on a valid/ready output. The accumulator is a separate instance: this block drives its clear, enable and data inputs and reads back its output. Used for gradient accumulation across BPTT time steps.

## Interface
- `WIDTH`, 32: data width, two's complement, same as the accumulator.
- `FRAC`, 24: fractional bits; passed through only, no arithmetic depends on it.
- `CNT_W`, 8: width of the sample-count field.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle job request; honoured only in IDLE.
- `len`  in  CNT_W  number of samples in the job; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  sample valid.
- `in_ready`  out  1  high only in RUN.
- `in_data`  in  WIDTH  sample value.
- `acc_clr`  out  1  registered active-high clear pulse to the accumulator reset.
- `acc_en`  out  1  accumulator enable, equal to `in_valid & in_ready`.
- `acc_i`  out  WIDTH  accumulator data input, equal to `in_data`.
- `acc_o`  in  WIDTH  accumulator output.
- `out_valid`  out  1  result valid; high only in DONE.
- `out_ready`  in  1  result accepted.
- `out_data`  out  WIDTH  result, equal to `acc_o` while in DONE, 0 otherwise.
- `ovf`  out  1  sticky overflow flag for the current job (see Configuration).

## Operation
- States: IDLE, CLEAR, RUN, DONE. Encoding is defined in the package.
- IDLE:
  - `start=1` latches `len` into `remain` and moves to CLEAR.
  - `start` in any other state is ignored.
- CLEAR: lasts 1 cycle.
  - `acc_clr=1`.
  - `ovf` is cleared.
  - Next state is RUN if `remain!=0`, else DONE.
- RUN:
  - `in_ready=1`.
  - Each beat (`in_valid & in_ready`) asserts `acc_en` in that cycle and decrements `remain`.
  - The beat with `remain==1` moves the block to DONE.
  - Cycles with `in_valid=0` are bubbles: no count and no enable.
- DONE:
  - `out_valid=1` and `acc_en=0`, so `acc_o` and `out_data` stay stable.
  - `out_valid & out_ready` returns the block to IDLE.
  - `start` in the same cycle as the acceptance is ignored.
- `len=0`: the job produces `out_data=0` with no input beats.
- Arithmetic is done entirely in the accumulator, which wraps modulo 2^WIDTH; this block adds no saturation.
- Reset asserted mid-job: the block returns to IDLE at once, all outputs go to their reset values and any partial sum is abandoned. The next job's CLEAR state clears the accumulator.

## Timing
- Reset values:
  - state IDLE, `remain=0`.
  - `busy`, `in_ready`, `acc_clr`, `acc_en`, `out_valid`, `ovf` all 0; `out_data=0`.
- `start` sampled at edge 0: CLEAR during cycle 1, RUN (`in_ready=1`) from cycle 2.
- Beats are accepted back-to-back, one per cycle.
- The last beat is accepted at edge k. The accumulator register updates at that same edge, so `out_valid=1` with the final `out_data` from cycle k+1.
- Job latency: with no bubbles, `len+2` cycles from `start` to `out_valid`.
- `acc_clr` comes from a register, so it is glitch-free.
- `acc_en` and `acc_i` are combinational from `in_valid` and `in_data`.

## Configuration
- `ACC_CTRL_OVF_EN` defined: overflow detection is compiled in.
  - On each beat, `ovf` is set when `acc_o` and `in_data` have the same sign and the sign of `acc_o + in_data` differs from it.
  - `ovf` is sticky until the next CLEAR and is valid alongside `out_valid`.
- Undefined: the `ovf` port is still present and tied to 0, and no adder is instantiated.

## Structure
- Package `acc_ctrl_pkg` holds:
  - the state enum (IDLE/CLEAR/RUN/DONE);
  - default `WIDTH`/`FRAC`/`CNT_W` constants shared with the accumulator.
- One sub-module: `acc_ovf_det`.
  - Combinational signed-add overflow detect on the operand pair.
  - Instantiated only under `ACC_CTRL_OVF_EN`.
- The accumulator is instantiated by the parent, not inside this block.

## Test plan
- Reset, then `start` with `len=3` and back-to-back samples 0x01000000, 0x02000000, 0xFF000000 → `acc_clr` high in cycle 1, `out_valid` in cycle 5, `out_data=0x02000000`.
- `len=4` with `in_valid` bubbles between every beat → exactly 4 `acc_en` pulses; result correct; `in_ready` never drops during RUN.
- `len=0` → CLEAR, then DONE with `out_data=0`; `out_ready` held low for 5 cycles → `out_valid` and `out_data` stay stable.
- `start` pulsed during RUN and DONE → ignored: `remain` is unchanged and no extra CLEAR occurs.
- Reset asserted in RUN after 2 of 5 beats → all outputs at reset values immediately; a following `len=1` job with 0x00000005 gives `out_data=0x00000005`.
- With `ACC_CTRL_OVF_EN` defined, `len=2`, samples 0x7F000000 twice → `ovf=1` with `out_valid`. The next job with `len=1` → `ovf=0`.

Source files
------------

// File: rtl/acc_ctrl_pkg.sv
// acc_ctrl_pkg: shared state encoding and default datapath widths for the
// accumulator sequencer and the accumulator it drives.
package acc_ctrl_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int FRAC_DEF  = 24;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/acc_ovf_det.sv
// acc_ovf_det: combinational two's-complement overflow detect for a + b.
// Only built when ACC_CTRL_OVF_EN is defined.
module acc_ovf_det
    import acc_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ovf
);

    // Same-sign operands whose wrapped sum flips sign.
    assign ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                 (((a + b) >> (WIDTH - 1)) != {{(WIDTH-1){1'b0}}, a[WIDTH-1]});

endmodule

// File: rtl/acc_ctrl.sv
// acc_ctrl: clears an external accumulator, feeds it len handshaked samples and
// presents the sum on valid/ready. ACC_CTRL_OVF_EN compiles in overflow detection.
module acc_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             acc_clr,
    output logic             acc_en,
    output logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] acc_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             ovf
);

    if (FRAC > WIDTH) begin : g_frac_chk
        $error("acc_ctrl: FRAC exceeds WIDTH");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             busy_q, in_ready_q, acc_clr_q, out_valid_q;
    logic             ovf_q, ovf_d, ovf_hit, beat;

    assign beat      = in_valid & in_ready_q;
    assign acc_en    = beat;
    assign acc_i     = in_data;
    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign acc_clr   = acc_clr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? acc_o : '0;
    assign ovf       = ovf_q;

`ifdef ACC_CTRL_OVF_EN
    acc_ovf_det #(.WIDTH(WIDTH)) u_ovf_det (
        .a   (acc_o),
        .b   (in_data),
        .ovf (ovf_hit)
    );
`else
    assign ovf_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CLEAR;
                    remain_d = len;
                end
            end
            CLEAR: begin
                state_d = (remain_q != '0) ? RUN : DONE;
                ovf_d   = 1'b0;
            end
            RUN: begin
                if (beat) begin
                    remain_d = remain_q - CNT_W'(1);
                    ovf_d    = ovf_q | ovf_hit;
                    state_d  = (remain_q == CNT_W'(1)) ? DONE : RUN;
                end
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are all flop outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            remain_q    <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            acc_clr_q   <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            busy_q      <= (state_d != IDLE);
            in_ready_q  <= (state_d == RUN);
            acc_clr_q   <= (state_d == CLEAR);
            out_valid_q <= (state_d == DONE);
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_acc_ctrl.sv
// tb_acc_ctrl: directed bench for acc_ctrl with a behavioural accumulator.
module tb_acc_ctrl;

    localparam int W = 32;
    localparam int C = 8;
`ifdef ACC_CTRL_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [C-1:0] len = '0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         busy, in_ready, acc_clr, acc_en, out_valid, ovf;
    logic [W-1:0] acc_i, out_data;
    logic [W-1:0] acc_q = '0;

    int n_vec = 0;
    int n_err = 0;

    acc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .acc_i     (acc_i),
        .acc_o     (acc_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (acc_clr) acc_q <= '0;
        else if (acc_en) acc_q <= acc_q + acc_i;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        #2;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        n_vec++; if (acc_clr !== 1'b0) begin n_err++; $display("FAIL reset acc_clr: got %b want 0", acc_clr); end
        n_vec++; if (acc_en !== 1'b0) begin n_err++; $display("FAIL reset acc_en: got %b want 0", acc_en); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset out_data: got %h want 0", out_data); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset ovf: got %b want 0", ovf); end
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset idle busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [W-1:0] d [3];
        d[0] = 32'h0100_0000; d[1] = 32'h0200_0000; d[2] = 32'hFF00_0000;
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        #1;
        n_vec++; if (acc_clr !== 1'b1) begin n_err++; $display("FAIL basic acc_clr c1: got %b want 1", acc_clr); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic busy c1: got %b want 1", busy); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic in_ready c1: got %b want 0", in_ready); end
        step();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = d[i];
            #1;
            n_vec++; if (acc_en !== 1'b1 || acc_i !== d[i]) begin n_err++; $display("FAIL basic beat%0d: got en=%b i=%h want en=1 i=%h", i, acc_en, acc_i, d[i]); end
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic early out_valid c%0d: got %b want 0", i + 2, out_valid); end
            step();
        end
        in_valid = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic out_valid c5: got %b want 1", out_valid); end
        n_vec++; if (out_data !== 32'h0200_0000) begin n_err++; $display("FAIL basic out_data: got %h want 02000000", out_data); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic in_ready done: got %b want 0", in_ready); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL basic ovf: got %b want 0", ovf); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0) begin n_err++; $display("FAIL basic idle: got busy=%b ov=%b od=%h want 0 0 0", busy, out_valid, out_data); end
    endtask

    task automatic test_bubbles();
        logic [W-1:0] v [4];
        int en_cnt, drops;
        v[0] = 32'h0000_0010; v[1] = 32'hFFFF_FFF0; v[2] = 32'h0000_0100; v[3] = 32'h0000_0005;
        en_cnt = 0; drops = 0;
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = v[i / 2];
            #1;
            if (acc_en === 1'b1) en_cnt++;
            if (i <= 6 && in_ready !== 1'b1) drops++;
            step();
        end
        in_valid = 1'b0;
        #1;
        n_vec++; if (en_cnt !== 4) begin n_err++; $display("FAIL bubbles acc_en count: got %0d want 4", en_cnt); end
        n_vec++; if (drops !== 0) begin n_err++; $display("FAIL bubbles in_ready drops: got %0d want 0", drops); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bubbles out_valid: got %b want 1", out_valid); end
        n_vec++; if (out_data !== 32'h0000_0105) begin n_err++; $display("FAIL bubbles out_data: got %h want 00000105", out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_len_zero();
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        #1;
        n_vec++; if (acc_clr !== 1'b1) begin n_err++; $display("FAIL len0 acc_clr: got %b want 1", acc_clr); end
        step();
        for (int i = 0; i < 6; i++) begin
            #1;
            n_vec++; if (out_valid !== 1'b1 || out_data !== 32'h0 || in_ready !== 1'b0) begin n_err++; $display("FAIL len0 hold%0d: got ov=%b od=%h rdy=%b want 1 0 0", i, out_valid, out_data, in_ready); end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL len0 idle busy: got %b want 0", busy); end
    endtask

    task automatic test_start_ignored();
        int clr_cnt;
        clr_cnt = 0;
        start = 1'b1; len = 8'd2;
        step();
        len = 8'd9;
        step();
        in_valid = 1'b1; in_data = 32'd7;
        #1;
        if (acc_clr === 1'b1) clr_cnt++;
        step();
        in_data = 32'd8;
        #1;
        if (acc_clr === 1'b1) clr_cnt++;
        step();
        in_valid = 1'b0;
        #1;
        if (acc_clr === 1'b1) clr_cnt++;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ignore out_valid: got %b want 1", out_valid); end
        n_vec++; if (out_data !== 32'd15) begin n_err++; $display("FAIL ignore out_data: got %h want 0000000f", out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        if (acc_clr === 1'b1) clr_cnt++;
        n_vec++; if (clr_cnt !== 0) begin n_err++; $display("FAIL ignore extra clear: got %0d want 0", clr_cnt); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore accept+start busy: got %b want 0", busy); end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        start = 1'b1; len = 8'd5;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b1; in_data = 32'd1;
        step();
        in_data = 32'd2;
        step();
        in_data = 32'd3;
        #1;
        rst = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || in_ready !== 1'b0 || acc_en !== 1'b0) begin n_err++; $display("FAIL midrst ctrl: got busy=%b rdy=%b en=%b want 0 0 0", busy, in_ready, acc_en); end
        n_vec++; if (acc_clr !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || ovf !== 1'b0) begin n_err++; $display("FAIL midrst out: got clr=%b ov=%b od=%h ovf=%b want 0 0 0 0", acc_clr, out_valid, out_data, ovf); end
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        #1;
        n_vec++; if (acc_clr !== 1'b1) begin n_err++; $display("FAIL midrst acc_clr: got %b want 1", acc_clr); end
        step();
        in_valid = 1'b1; in_data = 32'd5;
        #1;
        n_vec++; if (acc_en !== 1'b1) begin n_err++; $display("FAIL midrst beat: got %b want 1", acc_en); end
        step();
        in_valid = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b1 || out_data !== 32'd5) begin n_err++; $display("FAIL midrst result: got ov=%b od=%h want 1 00000005", out_valid, out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_ovf();
        start = 1'b1; len = 8'd2;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b1; in_data = 32'h7F00_0000;
        step();
        step();
        in_valid = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b1 || out_data !== 32'hFE00_0000) begin n_err++; $display("FAIL ovf result: got ov=%b od=%h want 1 fe000000", out_valid, out_data); end
        n_vec++; if (ovf !== OVF_EXP) begin n_err++; $display("FAIL ovf set: got %b want %b", ovf, OVF_EXP); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b1; in_data = 32'd1;
        step();
        in_valid = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b1 || ovf !== 1'b0) begin n_err++; $display("FAIL ovf cleared: got ov=%b ovf=%b want 1 0", out_valid, ovf); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_len_zero();
        test_start_ignored();
        test_reset_mid();
        test_ovf();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
